// File: rtl/axi_wr_resp_pkg.sv
// Shared types and helpers for the AXI write-response merge router.
//   resp_t      : BRESP encoding (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11)
//   resp_worst  : picks the more severe of two responses
//   rr_pick     : round-robin one-hot grant over up to RR_MAX requesters
package axi_wr_resp_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Widest requester vector rr_pick handles; callers zero-extend into it.
  localparam int unsigned RR_MAX = 32;

  // Severity rank: DECERR > SLVERR > OKAY > EXOKAY. EXOKAY is lowest so that
  // an accumulator seeded with EXOKAY passes a lone response through unchanged.
  function automatic logic [1:0] resp_rank(input resp_t r);
    case (r)
      EXOKAY:  return 2'd0;
      OKAY:    return 2'd1;
      SLVERR:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic resp_t resp_worst(input resp_t a, input resp_t b);
    return (resp_rank(a) >= resp_rank(b)) ? a : b;
  endfunction

  // Grants the first requester found scanning upward from ptr, wrapping at n.
  // ptr must be < n and n <= RR_MAX.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input int unsigned       ptr,
                                                input int unsigned       n);
    logic [RR_MAX-1:0] gnt;
    logic              found;
    int unsigned       idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && idx < RR_MAX) begin
        if (req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/wr_resp_split_fifo.sv
// Per-master split-descriptor FIFO: holds the sub-burst count K of each split
// write burst in issue order. The head is the K governing the merge in progress.
//   clk, reset        : clock, synchronous active-high reset
//   push, push_data   : write request (ignored when full) and descriptor
//   pop               : drop the head (ignored when empty)
//   full, empty, head : status derived from registered occupancy, head entry
// DEPTH must be a power of two and at least 2.
module wr_resp_split_fifo
  import axi_wr_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // Full comes from the registered count, so a pop while full only makes room
  // on the following cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers and count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_wr_resp_merge_router.sv
// Write-response router/merger. B beats from NUM_SLAVES slave ports are routed
// to NUM_MASTERS master ports by BID (BID = master index) with per-master
// round-robin arbitration; the sub-responses of a split burst are merged into a
// single master beat carrying the most severe BRESP.
//   clk, reset                     : clock, synchronous active-high reset
//   split_valid/ready/master/count : split descriptor push (K=0 treated as 1)
//   s_bresp/s_bvalid/s_bready      : master-side B channels (registered)
//   m_bid/m_bresp/m_bvalid/m_bready: slave-side B channels (ready is combinational)
//   compl_cnt                      : sub-responses merged so far per master
//   err_bid                        : pulse, a beat with an out-of-range BID was dropped
// NUM_SLAVES is limited to RR_MAX by the shared round-robin helper.
module axi_wr_resp_merge_router
  import axi_wr_resp_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int BID_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int CNT_W       = 4,
  parameter int SPLIT_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  split_valid,
  output logic                                  split_ready,
  input  logic [BID_W-1:0]                      split_master,
  input  logic [CNT_W-1:0]                      split_count,
  output logic [NUM_MASTERS-1:0][1:0]           s_bresp,
  output logic [NUM_MASTERS-1:0]                s_bvalid,
  input  logic [NUM_MASTERS-1:0]                s_bready,
  input  logic [NUM_SLAVES-1:0][BID_W-1:0]      m_bid,
  input  logic [NUM_SLAVES-1:0][1:0]            m_bresp,
  input  logic [NUM_SLAVES-1:0]                 m_bvalid,
  output logic [NUM_SLAVES-1:0]                 m_bready,
  output logic [NUM_MASTERS-1:0][CNT_W-1:0]     compl_cnt,
  output logic                                  err_bid
);

  localparam int              SIDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Per-master merge state.
  resp_t             acc_q   [NUM_MASTERS];
  logic [CNT_W-1:0]  cnt_q   [NUM_MASTERS];
  logic [SIDX_W-1:0] ptr_q   [NUM_MASTERS];

  // Per-master combinational decode.
  logic [NUM_MASTERS-1:0][NUM_SLAVES-1:0] req, gnt;
  logic [NUM_MASTERS-1:0]                 beat_acc, beat_final, fifo_push;
  logic [SIDX_W-1:0]                      gnt_idx   [NUM_MASTERS];
  resp_t                                  beat_resp [NUM_MASTERS];
  resp_t                                  merged    [NUM_MASTERS];
  logic [NUM_SLAVES-1:0]                  bid_bad;

  logic              fifo_full  [NUM_MASTERS];
  logic              fifo_empty [NUM_MASTERS];
  logic [CNT_W-1:0]  fifo_head  [NUM_MASTERS];

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_fifo
    wr_resp_split_fifo #(
      .DEPTH (SPLIT_DEPTH),
      .W     (CNT_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push[m]),
      .push_data (split_count),
      .pop       (beat_final[m]),
      .full      (fifo_full[m]),
      .empty     (fifo_empty[m]),
      .head      (fifo_head[m])
    );
  end

  always_comb begin
    logic [CNT_W:0] k_eff;
    logic           slot_free;
    logic           sel_full;
    // NOTE: every output of this block gets a default before any conditional
    // update, so no path leaves a value held and no latch is inferred.
    m_bready    = '0;
    req         = '0;
    gnt         = '0;
    beat_acc    = '0;
    beat_final  = '0;
    fifo_push   = '0;
    compl_cnt   = '0;
    k_eff       = '0;
    slot_free   = 1'b0;
    sel_full    = 1'b1;
    split_ready = 1'b0;

    for (int s = 0; s < NUM_SLAVES; s++) begin
      bid_bad[s] = m_bvalid[s] && (32'(m_bid[s]) >= 32'(NUM_MASTERS));
    end

    for (int m = 0; m < NUM_MASTERS; m++) begin
      gnt_idx[m]   = '0;
      beat_resp[m] = OKAY;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        req[m][s] = m_bvalid[s] && (32'(m_bid[s]) == 32'(m));
      end
      // A beat may only be taken when its result has somewhere to go, even a
      // non-final one; this keeps the slave stalled rather than buffering.
      slot_free = !s_bvalid[m] || s_bready[m];
      gnt[m]    = slot_free ? NUM_SLAVES'(rr_pick(RR_MAX'(req[m]), 32'(ptr_q[m]), NUM_SLAVES))
                            : '0;
      beat_acc[m] = |gnt[m];
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (gnt[m][s]) begin
          gnt_idx[m]   = SIDX_W'(s);
          beat_resp[m] = resp_t'(m_bresp[s]);
        end
        m_bready[s] = m_bready[s] | gnt[m][s];
      end
      // With no descriptor queued every beat is a complete (unsplit) response.
      k_eff = (fifo_empty[m] || fifo_head[m] == '0) ? (CNT_W+1)'(1) : {1'b0, fifo_head[m]};
      beat_final[m] = beat_acc[m] && (({1'b0, cnt_q[m]} + (CNT_W+1)'(1)) >= k_eff);
      merged[m]     = resp_worst(acc_q[m], beat_resp[m]);
      compl_cnt[m]  = cnt_q[m];
    end

    // Bad BIDs are always accepted so a misrouted beat cannot wedge its slave.
    for (int s = 0; s < NUM_SLAVES; s++) begin
      m_bready[s] = !reset && (m_bready[s] || bid_bad[s]);
    end

    // Out-of-range split_master matches no FIFO and stays rejected.
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (32'(split_master) == 32'(m)) sel_full = fifo_full[m];
    end
    split_ready = !reset && !sel_full;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      fifo_push[m] = split_valid && split_ready && (32'(split_master) == 32'(m));
    end
  end

  // NOTE: all state updates are non-blocking so every register in this block
  // computes from the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_bvalid <= '0;
      s_bresp  <= '0;
      err_bid  <= 1'b0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        acc_q[m] <= EXOKAY;
        cnt_q[m] <= '0;
        ptr_q[m] <= '0;
      end
    end else begin
      err_bid <= |(bid_bad & m_bready);
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (s_bvalid[m] && s_bready[m]) s_bvalid[m] <= 1'b0;
        if (beat_acc[m]) begin
          // Next search starts just after the slave that was served.
          ptr_q[m] <= (gnt_idx[m] == SIDX_W'(NUM_SLAVES - 1)) ? '0 : gnt_idx[m] + 1'b1;
          if (beat_final[m]) begin
            // Overrides the clear above when a new result loads on the
            // same cycle the previous one is taken.
            s_bvalid[m] <= 1'b1;
            s_bresp[m]  <= merged[m];
            cnt_q[m]    <= '0;
            acc_q[m]    <= EXOKAY;
          end else begin
            cnt_q[m] <= (cnt_q[m] == CNT_MAX) ? cnt_q[m] : cnt_q[m] + 1'b1;
            acc_q[m] <= merged[m];
          end
        end
      end
    end
  end

endmodule
